// File: rtl/flash_pkg.sv
// Shared definitions for the flash transmit and receive controllers.
package flash_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_ADDR_W = 4;

  // A programmed block length of zero selects a full 2^ADDR_W-word block.
  localparam int FULL_BLOCK_LEN = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_READ = 3'd2,
    ST_LOAD = 3'd3,
    ST_SEND = 3'd4,
    ST_NEXT = 3'd5,
    ST_IRQ  = 3'd6
  } flash_state_e;

endpackage

// File: rtl/flash_word_counter.sv
// Word counter for a flash block transfer: clear, count-enable and a
// last-word flag compared against the latched block length.
module flash_word_counter
  import flash_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic [ADDR_W-1:0] len,
  output logic [ADDR_W-1:0] count,
  output logic              last
);

  localparam logic [ADDR_W-1:0] FULL_LEN = ADDR_W'(FULL_BLOCK_LEN);

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + ADDR_W'(1);
    end
  end

  // Modulo arithmetic makes len-1 the all-ones index for the full block.
  assign last = (len == FULL_LEN) ? (count == '1) : (count == len - ADDR_W'(1));

endmodule

// File: rtl/flash_tx_controller.sv
// Block transmit controller: buffer RAM -> flash interface, one word per
// handshake, irq on completion. FLASH_TX_PARITY_EN adds the tx_parity output.
module flash_tx_controller
  import flash_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] length,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              irq,
  input  logic              irq_ack,
`ifdef FLASH_TX_PARITY_EN
  output logic              tx_parity,
`endif
  output logic [2:0]        state_dbg
);

  flash_state_e      state, state_next;
  logic [ADDR_W-1:0] len_reg;
  logic [ADDR_W-1:0] count;
  logic              cnt_clear, cnt_enable, cnt_last;

  flash_word_counter #(.ADDR_W(ADDR_W)) u_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .len    (len_reg),
    .count  (count),
    .last   (cnt_last)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= ST_IDLE;
      len_reg <= '0;
      tx_data <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && start) len_reg <= length;
      if (state == ST_LOAD) tx_data <= mem_rdata;
    end
  end

`ifdef FLASH_TX_PARITY_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_parity <= 1'b0;
    end else if (state == ST_LOAD) begin
      tx_parity <= ^mem_rdata;
    end
  end
`endif

  // Handshake: tx_valid is high only in SEND, where tx_data is held stable;
  // a word transfers on a rising edge with tx_valid && tx_ready both high.
  always_comb begin
    state_next = state;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          cnt_clear  = 1'b1;
          state_next = ST_ARM;
        end
      end
      ST_ARM: begin
        cnt_clear = 1'b1;
        if (!start) state_next = ST_READ;
      end
      ST_READ: state_next = ST_LOAD;
      ST_LOAD: state_next = ST_SEND;
      ST_SEND: begin
        if (tx_ready) state_next = ST_NEXT;
      end
      ST_NEXT: begin
        cnt_enable = 1'b1;
        state_next = cnt_last ? ST_IRQ : ST_READ;
      end
      ST_IRQ: begin
        if (irq_ack) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign mem_rd    = (state == ST_READ);
  assign mem_addr  = mem_rd ? count : '0;
  assign tx_valid  = (state == ST_SEND);
  assign busy      = (state != ST_IDLE);
  assign irq       = (state == ST_IRQ);
  assign state_dbg = state;

endmodule

// File: tb/tb_flash_tx_controller.sv
// Bench for flash_tx_controller: random buffer contents, lengths and stalls
// checked against a block-level model. Define FLASH_TX_PARITY_EN for parity.
module tb_flash_tx_controller;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] length = '0;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b0;
  logic              busy;
  logic              irq;
  logic              irq_ack = 1'b0;
  logic [2:0]        state_dbg;
`ifdef FLASH_TX_PARITY_EN
  logic              tx_parity;
`endif

  // clock / reset
  always #5 clock = ~clock;

  flash_tx_controller #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .length    (length),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .irq       (irq),
    .irq_ack   (irq_ack),
`ifdef FLASH_TX_PARITY_EN
    .tx_parity (tx_parity),
`endif
    .state_dbg (state_dbg)
  );

  // Buffer RAM model with a one-cycle synchronous read
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clock) if (mem_rd) mem_rdata <= mem[mem_addr];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard queues
  logic [DATA_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [DATA_W-1:0] obs_data_q[$];
  logic [ADDR_W-1:0] obs_addr_q[$];
  logic              obs_par_q[$];

  // Flash-side sink: withholds tx_ready stall_arr[k] cycles on word k
  int                stall_arr [DEPTH];
  int                word_idx  = 0;
  int                cur_wait  = 0;
  int                irq_rises = 0;
  logic              irq_prev  = 1'b0;
  logic [DATA_W-1:0] hold_data = '0;

  always @(negedge clock) begin
    if (reset) begin
      if (mem_rd) obs_addr_q.push_back(mem_addr);
      if (irq && !irq_prev) irq_rises++;
      if (tx_valid) begin
        if (cur_wait == 0) hold_data = tx_data;
        else chk("stall_data_stable", tx_data, hold_data);
        if (cur_wait < stall_arr[word_idx % DEPTH]) begin
          tx_ready = 1'b0;
          cur_wait++;
        end else begin
          tx_ready = 1'b1;
          obs_data_q.push_back(tx_data);
`ifdef FLASH_TX_PARITY_EN
          obs_par_q.push_back(tx_parity);
`endif
          word_idx++;
          cur_wait = 0;
        end
      end else begin
        tx_ready = 1'($urandom_range(0, 1));
      end
    end
    irq_prev = irq;
  end

  // Driver: one complete block; called and returns on a negedge
  task automatic run_block(input int len_v, input int hold, input int max_stall,
                           input int stall0, input bit tog);
    int n, stall_sum, cyc, rises0, k;
    n = (len_v == 0) ? DEPTH : len_v;
    exp_q.delete(); exp_addr_q.delete();
    obs_data_q.delete(); obs_addr_q.delete(); obs_par_q.delete();
    word_idx = 0;
    cur_wait = 0;
    stall_sum = 0;
    for (int i = 0; i < DEPTH; i++) stall_arr[i] = $urandom_range(0, max_stall);
    if (stall0 >= 0) stall_arr[0] = stall0;
    for (int i = 0; i < n; i++) begin
      stall_sum += stall_arr[i];
      exp_q.push_back(mem[i]);
      exp_addr_q.push_back(ADDR_W'(i));
    end
    rises0 = irq_rises;

    start  = 1'b1;
    length = ADDR_W'(len_v);
    repeat (hold - 1) begin
      @(negedge clock);
      chk("hold_no_rd", mem_rd, 1'b0);
    end
    @(negedge clock);
    chk("hold_busy", busy, 1'b1);
    chk("hold_no_rd_last", mem_rd, 1'b0);
    start = 1'b0;
    @(negedge clock);
    chk("first_rd", mem_rd, 1'b1);
    chk("first_addr", mem_addr, '0);

    cyc = 0;
    while (irq !== 1'b1 && cyc < 4000) begin
      if (tog) start = 1'($urandom_range(0, 1));
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    chk("irq_raised", irq, 1'b1);
    chk("block_cycles", cyc, 4 * n + stall_sum);

    chk("n_words", obs_data_q.size(), n);
    chk("n_addrs", obs_addr_q.size(), n);
    foreach (exp_q[i]) begin
      if (i < obs_data_q.size()) chk("word_data", obs_data_q[i], exp_q[i]);
      if (i < obs_addr_q.size()) chk("word_addr", obs_addr_q[i], exp_addr_q[i]);
`ifdef FLASH_TX_PARITY_EN
      if (i < obs_par_q.size()) chk("word_parity", obs_par_q[i], ^exp_q[i]);
`endif
    end

    k = $urandom_range(1, 4);
    repeat (k) begin
      @(negedge clock);
      chk("irq_hold", irq, 1'b1);
    end
    chk("irq_hold_busy", busy, 1'b1);
    irq_ack = 1'b1;
    @(negedge clock);
    irq_ack = 1'b0;
    chk("ack_busy", busy, 1'b0);
    chk("ack_irq", irq, 1'b0);
    chk("ack_state", state_dbg, 3'd0);
    chk("irq_once", irq_rises - rises0, 1);
  endtask

  initial begin
    int quiet;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
      stall_arr[i] = 0;
    end

    // Reset state
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_mem_rd", mem_rd, 1'b0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_tx_data", tx_data, '0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_state", state_dbg, 3'd0);
    reset = 1'b1;
    @(negedge clock);

    // irq_ack while idle is ignored
    irq_ack = 1'b1;
    @(negedge clock);
    irq_ack = 1'b0;
    @(negedge clock);
    chk("idle_ack_busy", busy, 1'b0);
    chk("idle_ack_irq", irq, 1'b0);

    // Basic block A0..A3
    for (int i = 0; i < 4; i++) mem[i] = 8'hA0 + 8'(i);
    run_block(4, 2, 0, 0, 1'b0);

    // Backpressure: word 0 stalled 5 cycles
    run_block(2, 2, 0, 5, 1'b0);

    // Reset mid-SEND
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
    word_idx = 0;
    cur_wait = 0;
    stall_arr[0] = 40;
    start  = 1'b1;
    length = 4'd3;
    @(negedge clock);
    start = 1'b0;
    quiet = 0;
    while (tx_valid !== 1'b1 && quiet < 20) begin
      @(negedge clock);
      quiet++;
    end
    chk("reach_send", tx_valid, 1'b1);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("mid_rst_tx_valid", tx_valid, 1'b0);
      chk("mid_rst_irq", irq, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_mem_rd", mem_rd, 1'b0);
      chk("mid_rst_state", state_dbg, 3'd0);
    end
    reset = 1'b1;
    quiet = 0;
    repeat (30) begin
      @(negedge clock);
      if (busy !== 1'b0 || irq !== 1'b0) quiet++;
    end
    chk("post_rst_quiet", quiet, 0);
    stall_arr[0] = 0;

    // Full block (length 0) with random stalls and start toggling
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
    run_block(0, 3, 2, -1, 1'b1);

    // start held 10 cycles; new transfer restarts at address 0
    run_block(5, 10, 1, -1, 1'b0);

    // Random blocks
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
      run_block($urandom_range(0, 15), $urandom_range(1, 6), $urandom_range(0, 3), -1, 1'b1);
    end

`ifdef FLASH_TX_PARITY_EN
    mem[0] = 8'h07;
    mem[1] = 8'h03;
    run_block(2, 1, 0, -1, 1'b0);
    if (obs_par_q.size() == 2) begin
      chk("parity_07", obs_par_q[0], 1'b1);
      chk("parity_03", obs_par_q[1], 1'b0);
    end else begin
      chk("parity_count", obs_par_q.size(), 2);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
